serial_add_sub_ctrl: RTL and testbench

Bit-serial sequencer for the 1-bit full-adder/subtractor cell in the arithmetic unit (Rechenwerk).
- Accepts two WIDTH-bit operands and an add/subtract command.
- Drives one internal 1-bit add/sub cell (A, B, Cin, Binv → Sum, Cout) for WIDTH cycles, LSB first, and assembles the result.
- Reports unsigned carry and signed overflow with a start/busy/done handshake.
- Trades WIDTH cycles of latency for a single adder cell.

---
 rtl/serial_add_sub_ctrl.sv | 132 +++++++++++++
 tb/tb_serial_add_sub_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell is reused LSB-first over WIDTH cycles.
// Optional macro SERIAL_ADD_SUB_SAT_EN saturates the result on signed overflow instead of wrapping.
module serial_add_sub_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned RW = WIDTH - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [RW-1:0]    res_sh_q;
  logic [CW-1:0]    cnt_q;
  logic             sub_q;
  logic             carry_q;
  logic             c_msb_in_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             ovf_q;

  logic             b_eff_c;
  logic             sum_c;
  logic             cell_cout_c;
  logic             last_c;
  logic             ovf_c;
  logic [WIDTH-1:0] full_c;
  logic [WIDTH-1:0] final_c;

  // The single add/sub cell plus the end-of-operation result/flag formation.
  always_comb begin
    b_eff_c     = b_sh_q[0] ^ sub_q;
    sum_c       = a_sh_q[0] ^ b_eff_c ^ carry_q;
    cell_cout_c = (a_sh_q[0] & b_eff_c) | (carry_q & (a_sh_q[0] ^ b_eff_c));
    last_c      = (cnt_q == CW'(WIDTH - 1));
    ovf_c       = c_msb_in_q ^ cell_cout_c;
    full_c      = {sum_c, res_sh_q};
    final_c     = full_c;
`ifdef SERIAL_ADD_SUB_SAT_EN
    // A set wrapped sign bit on overflow means the true result was positive.
    if (ovf_c) begin
      final_c = sum_c ? {1'b0, {RW{1'b1}}} : {1'b1, {RW{1'b0}}};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      res_sh_q   <= '0;
      cnt_q      <= '0;
      sub_q      <= 1'b0;
      carry_q    <= 1'b0;
      c_msb_in_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            sub_q   <= sub;
            carry_q <= sub;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          carry_q <= cell_cout_c;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 2)) begin
            c_msb_in_q <= cell_cout_c;
          end
          if (last_c) begin
            result_q <= final_c;
            cout_q   <= cell_cout_c;
            ovf_q    <= ovf_c;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            res_sh_q <= RW'({sum_c, res_sh_q} >> 1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_add_sub_ctrl.sv
// Self-checking bench for serial_add_sub_ctrl (WIDTH=8) against an integer-arithmetic reference model.
module tb_serial_add_sub_ctrl;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_add_sub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {overflow, cout, result} from signed/unsigned integer arithmetic.
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
    int   ux, uy, sx, sy, st;
    logic c, v;
    logic [7:0] r;
    ux = int'(x);
    uy = int'(y);
    sx = x[7] ? ux - 256 : ux;
    sy = y[7] ? uy - 256 : uy;
    st = s ? sx - sy : sx + sy;
    v  = (st > 127) || (st < -128);
    c  = s ? (ux >= uy) : (ux + uy > 255);
    r  = s ? 8'(ux - uy) : 8'(ux + uy);
`ifdef SERIAL_ADD_SUB_SAT_EN
    if (v) r = (st > 0) ? 8'h7F : 8'h80;
`endif
    return {v, c, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits after an accepted start (k=0 is just after T0) until done, bounded.
  task automatic wait_done(input bit poke, output int k, output int nb);
    k  = 0;
    nb = 0;
    while (!done && k < 30) begin
      if (busy) nb++;
      if (poke && k == 3) start = 1'b1;
      if (poke && k == 4) start = 1'b0;
      if (poke) begin
        a = 8'($urandom);
        b = 8'($urandom);
      end
      tick();
      k++;
    end
  endtask

  task automatic check_op(input string tag, input logic [7:0] x, input logic [7:0] y,
                          input logic s, input int k, input int nb);
    logic [9:0] e;
    e = model(x, y, s);
    chk({tag, "_latency"}, 32'(k), 32'(WIDTH));
    chk({tag, "_busy_cycles"}, 32'(nb), 32'(WIDTH));
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, "_result"}, 32'(result), 32'(e[7:0]));
    chk({tag, "_cout"}, 32'(cout), 32'(e[8]));
    chk({tag, "_overflow"}, 32'(overflow), 32'(e[9]));
  endtask

  task automatic run_op(input string tag, input logic [7:0] x, input logic [7:0] y,
                        input logic s, input bit poke);
    int k, nb;
    logic [9:0] e;
    e = model(x, y, s);
    a = x;
    b = y;
    sub = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    sub = 1'($urandom);
    wait_done(poke, k, nb);
    check_op(tag, x, y, s, k, nb);
    tick();
    chk({tag, "_done_drop"}, 32'(done), 32'd0);
    chk({tag, "_result_hold"}, 32'(result), 32'(e[7:0]));
  endtask

  logic [7:0] ops_a [6];
  logic [7:0] ops_b [6];
  logic       ops_s [6];

  initial begin
    int k, nb, seen;
    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    tick();

    run_op("add_5_3", 8'h05, 8'h03, 1'b0, 1'b0);
    run_op("sub_5_3", 8'h05, 8'h03, 1'b1, 1'b0);
    run_op("sub_3_5", 8'h03, 8'h05, 1'b1, 1'b0);
    run_op("add_7f_1", 8'h7F, 8'h01, 1'b0, 1'b0);
    run_op("sub_80_1", 8'h80, 8'h01, 1'b1, 1'b0);
    run_op("add_ff_1_poke", 8'hFF, 8'h01, 1'b0, 1'b1);
    run_op("add_12_34", 8'h12, 8'h34, 1'b0, 1'b0);

    // Abort in the 4th RUN cycle.
    a = 8'h5A;
    b = 8'h33;
    sub = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_overflow", 32'(overflow), 32'd0);
    seen = 0;
    repeat (12) begin
      tick();
      if (done) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    run_op("add_10_20", 8'h10, 8'h20, 1'b0, 1'b0);

    // Back-to-back with start held high.
    for (int i = 0; i < 6; i++) begin
      ops_a[i] = 8'($urandom);
      ops_b[i] = 8'($urandom);
      ops_s[i] = 1'($urandom);
    end
    a = ops_a[0];
    b = ops_b[0];
    sub = ops_s[0];
    start = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      if (i + 1 < 6) begin
        a = ops_a[i+1];
        b = ops_b[i+1];
        sub = ops_s[i+1];
      end else begin
        start = 1'b0;
      end
      wait_done(1'b0, k, nb);
      check_op($sformatf("b2b_%0d", i), ops_a[i], ops_b[i], ops_s[i], k, nb);
      tick();
    end
    chk("b2b_final_idle_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 20; i++) begin
      run_op($sformatf("rand_%0d", i), 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
